// File: rtl/smg_pkg.sv
// Shared constants, digit-entry layout and FSM state type for the
// six-digit seven-segment scan scheduler.
package smg_pkg;

  localparam int NUM_DIGITS = 6;

  // One digit entry: [3:0] hex nibble, [4] decimal point on, [5] blank digit
  localparam int DIGIT_W       = 6;
  localparam int DIG_NIB_LSB   = 0;
  localparam int DIG_NIB_W     = 4;
  localparam int DIG_DP_BIT    = 4;
  localparam int DIG_BLANK_BIT = 5;

  localparam logic [DIGIT_W-1:0] DIGIT_BLANK = 6'h20;

  // All segments dark / no digit selected (both active-low)
  localparam logic [7:0] SEG_OFF  = 8'hFF;
  localparam logic [5:0] SCAN_OFF = 6'h3F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  typedef logic [DIGIT_W-1:0] digit_t;

  // One-cold digit select for digit index idx
  function automatic logic [5:0] scan_select(input logic [2:0] idx);
    return ~(6'd1 << idx);
  endfunction

endpackage

// File: rtl/smg_seg_decode.sv
// Combinational hex-to-seven-segment decoder, active-low outputs.
// seg[7] is the decimal point, seg[6:0] are segments g..a.
module smg_seg_decode
  import smg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);

  logic [6:0] glyph;

  // Standard hex glyphs, g..a, low = lit
  always_comb begin
    glyph = 7'h7F;
    case (nibble)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      4'hF: glyph = 7'h0E;
      default: glyph = 7'h7F;
    endcase
  end

  // Blank overrides everything; otherwise dp lit clears bit 7
  always_comb begin
    seg = SEG_OFF;
    if (!blank) begin
      seg = {~dp, glyph};
    end
  end

endmodule

// File: rtl/smg_scan_sched.sv
// Six-digit multiplexed display scan scheduler. A host fills a shadow image;
// a Commit request copies it to the active image at the next frame boundary
// (entry into the blanking slot ahead of digit 0), so a half-written image is
// never displayed. Each digit is shown for DWELL_CYCLES, separated by
// BLANK_CYCLES of all-off to avoid ghosting. All outputs are registered and
// Scan_Sig/SMG_Data always change on the same edge.
//
// Host interface: Wr_En is a single-cycle strobe with no ready; writes are
// accepted every cycle and never stall. Commit is a pulse; Commit_Pending
// reports an accepted request not yet applied.
module smg_scan_sched
  import smg_pkg::*;
#(
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int CNT_W        = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Enable,
  input  logic       Wr_En,
  input  logic [2:0] Wr_Addr,
  input  logic [5:0] Wr_Data,
  input  logic       Commit,
  output logic       Commit_Pending,
  output logic       Frame_Start,
  output logic [7:0] SMG_Data,
  output logic [5:0] Scan_Sig
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [2:0]       LAST_IDX   = 3'(NUM_DIGITS - 1);
  localparam logic [2:0]       DIGITS_3B  = 3'(NUM_DIGITS);

  state_t           state, state_next;
  logic [2:0]       idx, idx_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [5:0]       scan_next;
  logic [7:0]       seg_next;
  logic             fs_next;
  logic             frame_edge;

  digit_t shadow [NUM_DIGITS];
  digit_t active [NUM_DIGITS];
  digit_t cur_digit;
  logic [7:0] cur_seg;

  // The digit currently indexed by the scan is the only one ever decoded
  assign cur_digit = active[idx];

  smg_seg_decode u_decode (
    .nibble (cur_digit[DIG_NIB_LSB +: DIG_NIB_W]),
    .dp     (cur_digit[DIG_DP_BIT]),
    .blank  (cur_digit[DIG_BLANK_BIT]),
    .seg    (cur_seg)
  );

  // Next-state, slot counter, digit index and next registered outputs
  always_comb begin
    state_next = state;
    idx_next   = idx;
    cnt_next   = cnt + 1'b1;
    scan_next  = SCAN_OFF;
    seg_next   = SEG_OFF;
    fs_next    = 1'b0;
    frame_edge = 1'b0;
    if (!Enable) begin
      state_next = IDLE;
      idx_next   = '0;
      cnt_next   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          // Starting a scan enters the blank ahead of digit 0: a frame boundary
          state_next = BLANK;
          idx_next   = '0;
          cnt_next   = '0;
          frame_edge = 1'b1;
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_next = SHOW;
            cnt_next   = '0;
            scan_next  = scan_select(idx);
            seg_next   = cur_seg;
            fs_next    = (idx == 3'd0);
          end
        end
        SHOW: begin
          if (cnt == DWELL_LAST) begin
            state_next = BLANK;
            cnt_next   = '0;
            if (idx == LAST_IDX) begin
              idx_next   = '0;
              frame_edge = 1'b1;
            end else begin
              idx_next = idx + 1'b1;
            end
          end else begin
            scan_next = scan_select(idx);
            seg_next  = cur_seg;
          end
        end
        default: begin
          state_next = IDLE;
          idx_next   = '0;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // State register and registered display outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      Scan_Sig    <= SCAN_OFF;
      SMG_Data    <= SEG_OFF;
      Frame_Start <= 1'b0;
    end else begin
      state       <= state_next;
      idx         <= idx_next;
      cnt         <= cnt_next;
      Scan_Sig    <= scan_next;
      SMG_Data    <= seg_next;
      Frame_Start <= fs_next;
    end
  end

  // Image banks and commit flag. The transfer copies the pre-edge shadow, so
  // a write in the transfer cycle lands in shadow only; a Commit in that cycle
  // re-arms the flag for the following frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= DIGIT_BLANK;
        active[i] <= DIGIT_BLANK;
      end
      Commit_Pending <= 1'b0;
    end else begin
      if (frame_edge && Commit_Pending) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          active[i] <= shadow[i];
        end
        Commit_Pending <= Commit;
      end else begin
        Commit_Pending <= Commit_Pending | Commit;
      end
      if (Wr_En && (Wr_Addr < DIGITS_3B)) begin
        shadow[Wr_Addr] <= Wr_Data;
      end
    end
  end

endmodule

// File: doc/smg_scan_sched.md
# smg_scan_sched

Scan scheduler for the board's 6-digit multiplexed seven-segment display. It holds a double-buffered digit image written by a host-side register interface, then time-multiplexes the six digits onto `SMG_Data`/`Scan_Sig`. Between digits it inserts a blanking interval so that no segment ghosts onto the neighbouring digit. A staged image becomes visible only at a frame boundary, so a partially written image is never displayed.

## Interface
Parameters:
- `DWELL_CYCLES`, 50000: cycles each digit is driven (1 ms at 50 MHz); minimum 1.
- `BLANK_CYCLES`, 500: cycles all digits are off between consecutive digits; minimum 1.
- `CNT_W`, 16: width of the slot counter; must hold max(DWELL_CYCLES, BLANK_CYCLES) - 1.

Ports:
- `CLK`, in, 1: the single clock; all logic is on its rising edge.
- `RST`, in, 1: synchronous reset, active-high.
- `Enable`, in, 1: run scan while high.
- `Wr_En`, in, 1: single-cycle write strobe into the shadow image.
- `Wr_Addr`, in, 3: digit index 0..5; values 6 and 7 are ignored.
- `Wr_Data`, in, 6: `[3:0]` hex nibble, `[4]` decimal point on, `[5]` blank digit.
- `Commit`, in, 1: pulse that requests shadow-to-active transfer at the next frame boundary.
- `Commit_Pending`, out, 1: a commit is requested but not yet applied.
- `Frame_Start`, out, 1: one-cycle pulse when digit 0 begins its SHOW slot.
- `SMG_Data`, out, 8: active-low segments; `[7]`=dp, `[6:0]`=g..a.
- `Scan_Sig`, out, 6: active-low digit select, one-cold; bit i selects digit i.

## Operation
- Two 6x6-bit banks: shadow (written by `Wr_En`) and active (displayed). Writes are accepted every cycle and never stall.
- FSM states:
  - IDLE: outputs off, digit index = 0.
  - BLANK: `Scan_Sig`=6'h3F, `SMG_Data`=8'hFF, lasts `BLANK_CYCLES`.
  - SHOW: digit `idx` driven, lasts `DWELL_CYCLES`.
- FSM transitions:
  - IDLE→BLANK when `Enable`=1.
  - BLANK→SHOW when the slot counter expires.
  - SHOW→BLANK when the slot counter expires; idx increments, wrapping 5→0.
  - Any state→IDLE in the cycle after `Enable`=0.
- Frame boundary is entry into the BLANK that precedes digit 0, including IDLE→BLANK. If `Commit_Pending`=1 at that point, all six active entries load from shadow and `Commit_Pending` clears.
- Decode: the hex nibble maps to standard segments, active-low, with dp off. Reference values: 0→C0, 1→F9, 8→80, A→88, F→8E. Decimal point on clears bit 7. Blank bit set → 8'hFF regardless of nibble/dp.
- Boundary cases:
  - `Commit` while already pending: no change.
  - `Commit` in the transfer cycle: transfer uses the prior pending flag, and the new request sets pending for the next frame.
  - `Wr_En` in the transfer cycle: the write lands in shadow only and is not part of this transfer.
  - `Wr_En` and `Commit` in the same non-transfer cycle: the write is included in the eventual transfer.
  - `Enable` dropped mid-SHOW: outputs off on the next cycle. Banks and `Commit_Pending` are retained.
  - `RST` mid-operation: every register returns to its reset value on the next edge.

## Timing
- Reset values:
  - state IDLE, idx 0, counter 0.
  - `Scan_Sig`=6'h3F, `SMG_Data`=8'hFF.
  - `Frame_Start`=0, `Commit_Pending`=0.
  - both banks 6'h20 (blank).
- All outputs are registered. `Scan_Sig` and `SMG_Data` change on the same edge, so there is no mixed-digit cycle.
- `Enable` rising at edge N puts the FSM in BLANK from N+1. Digit 0 appears at N+1+`BLANK_CYCLES`, and `Frame_Start` is high in that same cycle.
- Frame period is 6*(`DWELL_CYCLES`+`BLANK_CYCLES`) cycles.
- `Commit_Pending` rises the cycle after `Commit`. Worst-case commit-to-display latency is one frame plus `BLANK_CYCLES`.

## Structure
- Package `smg_pkg`:
  - `NUM_DIGITS`=6.
  - FSM state enum {IDLE, BLANK, SHOW}.
  - digit entry field offsets.
  - constants `SEG_OFF`=8'hFF and `SCAN_OFF`=6'h3F.
- Sub-module `smg_seg_decode`: combinational, input nibble/dp/blank, output 8-bit active-low segments. It is instantiated once on the selected active entry before the output register.

## Test plan
Bench parameters: `DWELL_CYCLES`=4, `BLANK_CYCLES`=2 (frame = 36 cycles).
- Reset then `Enable`=1 with no writes → `Scan_Sig` walks 3E,3D,3B,37,2F,1F, each for 4 cycles with 2 cycles of 3F between. `SMG_Data` stays FF throughout.
- Write digits 0..5 = 0,1,8,A,F,8+dp, then `Commit` → from the next frame `SMG_Data` per slot is C0,F9,80,88,8E,00. `Commit_Pending` is 1 until the frame boundary.
- Write digit 2=1 mid-frame without `Commit` → display unchanged for 3 frames. After `Commit`, digit 2 shows F9 starting exactly at the next digit-0 frame boundary.
- `Commit` and a write in the transfer cycle → the old image transfers, `Commit_Pending` stays 1, and the new value appears one frame later.
- Drop `Enable` during digit 3 SHOW → next cycle `Scan_Sig`=3F and `SMG_Data`=FF. On re-enable, digit 0 appears 2 cycles later with `Frame_Start` pulsing.
- Writes to `Wr_Addr` 6/7, and `RST` asserted mid-SHOW → no bank change from the writes. After reset, all outputs and `Commit_Pending` are at their reset values on the next edge.
